// File: rtl/dram_init_sequencer.sv
// DDR3 power-up / initialization sequencer.
// Walks reset, CKE, mode-register and ZQ calibration phases for every rank
// in turn. Commands go to the PHY via a valid/ready handshake. init_done
// tells the scheduler that it now owns the command bus.
module dram_init_sequencer #(
  parameter int NUM_RANKS = 1,
  parameter int NUM_MRS   = 4,
  parameter int CNT_W     = 20,
  parameter int T_RESET   = 200,
  parameter int T_CKE     = 500,
  parameter int T_XPR     = 5,
  parameter int T_MRD     = 4,
  parameter int T_MOD     = 12,
  parameter int T_ZQINIT  = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_start,
  input  logic [NUM_MRS*17-1:0]  mr_table,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [3:0]             cmd,
  output logic [2:0]             ba,
  output logic [13:0]            addr,
  output logic [NUM_RANKS-1:0]   cs_n,
  output logic                   dram_reset_n,
  output logic                   cke,
  output logic [3:0]             init_state,
  output logic                   init_done
);

  localparam logic [3:0] ST_POWER_UP        = 4'd0;
  localparam logic [3:0] ST_RESET_PROCEDURE = 4'd1;
  localparam logic [3:0] ST_WAIT_TXPR       = 4'd2;
  localparam logic [3:0] ST_ZQ              = 4'd3;
  localparam logic [3:0] ST_LMR             = 4'd4;
  localparam logic [3:0] ST_WAIT_TDLLK      = 4'd5;
  localparam logic [3:0] ST_INIT_DONE       = 4'd6;
  localparam logic [3:0] ST_WAIT_TMOD       = 4'd7;
  localparam logic [3:0] ST_NOP_BEFORE_MRS  = 4'd9;
  localparam logic [3:0] ST_NOP_MRS_ZQ      = 4'd10;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_ZQCAL = 4'd8;
  localparam logic [3:0] CMD_MRS   = 4'd9;

  localparam int RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int MR_W   = (NUM_MRS > 1) ? $clog2(NUM_MRS) : 1;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Counters hold T-1, so every timing value must fit after the decrement.
  if (NUM_RANKS < 1 || NUM_MRS < 1 || CNT_W < 1 || CNT_W > 32) begin : g_bad_shape
    $error("dram_init_sequencer: NUM_RANKS/NUM_MRS must be >= 1 and CNT_W in 1..32");
  end
  if (longint'(T_RESET) - 1 > CNT_MAX || longint'(T_CKE) - 1 > CNT_MAX ||
      longint'(T_XPR) - 1 > CNT_MAX || longint'(T_MRD) - 1 > CNT_MAX ||
      longint'(T_MOD) - 1 > CNT_MAX || longint'(T_ZQINIT) - 1 > CNT_MAX) begin : g_bad_timing
    $error("dram_init_sequencer: a timing parameter does not fit in CNT_W bits");
  end

  // A zero timing value still costs one wait cycle.
  function automatic logic [CNT_W-1:0] load_of(input int t);
    return (t <= 1) ? '0 : CNT_W'(t - 1);
  endfunction

  logic [3:0]           state_q, state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [RANK_W-1:0]    rank_idx_q, rank_idx_d;
  logic [MR_W-1:0]      mr_idx_q, mr_idx_d;
  logic                 started_q, started_d;
  logic                 init_start_q;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [2:0]           ba_q, ba_d;
  logic [13:0]          addr_q, addr_d;
  logic [NUM_RANKS-1:0] cs_n_q, cs_n_d;
  logic                 dram_reset_n_q, dram_reset_n_d;
  logic                 cke_q, cke_d;
  logic                 init_done_q, init_done_d;
  logic                 cnt_zero;
  logic                 accept;

  assign cnt_zero = (counter_q == '0);
  assign accept   = cmd_valid_q && cmd_ready;

  // Next-state, timing counter and rank/table index sequencing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    counter_d  = cnt_zero ? counter_q : counter_q - CNT_W'(1);
    rank_idx_d = rank_idx_q;
    mr_idx_d   = mr_idx_q;
    started_d  = started_q;
    case (state_q)
      ST_POWER_UP: begin
        if (!started_q) begin
          counter_d = '0;
          if (init_start) begin
            started_d = 1'b1;
            counter_d = load_of(T_RESET);
          end
        end else if (cnt_zero) begin
          started_d = 1'b0;
          state_d   = ST_RESET_PROCEDURE;
          counter_d = load_of(T_CKE);
        end
      end
      ST_RESET_PROCEDURE: if (cnt_zero) begin
        state_d   = ST_WAIT_TXPR;
        counter_d = load_of(T_XPR);
      end
      ST_WAIT_TXPR, ST_NOP_BEFORE_MRS, ST_NOP_MRS_ZQ: if (cnt_zero) state_d = ST_LMR;
      ST_LMR: if (accept) begin
        if (int'(mr_idx_q) < NUM_MRS - 1) begin
          mr_idx_d  = mr_idx_q + MR_W'(1);
          state_d   = ST_NOP_BEFORE_MRS;
          counter_d = load_of(T_MRD);
        end else begin
          state_d   = ST_WAIT_TMOD;
          counter_d = load_of(T_MOD);
        end
      end
      ST_WAIT_TMOD: if (cnt_zero) state_d = ST_ZQ;
      ST_ZQ: if (accept) begin
        state_d   = ST_WAIT_TDLLK;
        counter_d = load_of(T_ZQINIT);
      end
      ST_WAIT_TDLLK: if (cnt_zero) begin
        if (int'(rank_idx_q) < NUM_RANKS - 1) begin
          rank_idx_d = rank_idx_q + RANK_W'(1);
          mr_idx_d   = '0;
          state_d    = ST_NOP_MRS_ZQ;
          counter_d  = load_of(T_MRD);
        end else begin
          state_d = ST_INIT_DONE;
        end
      end
      ST_INIT_DONE: if (init_start && !init_start_q) begin
        state_d    = ST_POWER_UP;
        started_d  = 1'b1;
        counter_d  = load_of(T_RESET);
        rank_idx_d = '0;
        mr_idx_d   = '0;
      end
      default: begin
        state_d    = ST_POWER_UP;
        started_d  = 1'b0;
        counter_d  = '0;
        rank_idx_d = '0;
        mr_idx_d   = '0;
      end
    endcase
  end

  // Output values decoded from the next state so the registered pins track init_state.
  always_comb begin
    cmd_valid_d    = 1'b0;
    cmd_d          = CMD_NOP;
    ba_d           = '0;
    addr_d         = '0;
    cs_n_d         = '1;
    dram_reset_n_d = (state_d != ST_POWER_UP);
    cke_d          = (state_d != ST_POWER_UP) && (state_d != ST_RESET_PROCEDURE);
    init_done_d    = (state_d == ST_INIT_DONE);
    case (state_d)
      ST_LMR: begin
        cmd_valid_d     = 1'b1;
        cmd_d           = CMD_MRS;
        {ba_d, addr_d}  = mr_table[int'(mr_idx_d) * 17 +: 17];
        cs_n_d          = ~(NUM_RANKS'(1) << rank_idx_d);
      end
      ST_ZQ: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_ZQCAL;
        addr_d[10]  = 1'b1;
        cs_n_d      = ~(NUM_RANKS'(1) << rank_idx_d);
      end
      default: ;
    endcase
  end

  // State and output registers; reset drops any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_POWER_UP;
      counter_q      <= '0;
      rank_idx_q     <= '0;
      mr_idx_q       <= '0;
      started_q      <= 1'b0;
      init_start_q   <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= CMD_NOP;
      ba_q           <= '0;
      addr_q         <= '0;
      cs_n_q         <= '1;
      dram_reset_n_q <= 1'b0;
      cke_q          <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      counter_q      <= counter_d;
      rank_idx_q     <= rank_idx_d;
      mr_idx_q       <= mr_idx_d;
      started_q      <= started_d;
      init_start_q   <= init_start;
      cmd_valid_q    <= cmd_valid_d;
      cmd_q          <= cmd_d;
      ba_q           <= ba_d;
      addr_q         <= addr_d;
      cs_n_q         <= cs_n_d;
      dram_reset_n_q <= dram_reset_n_d;
      cke_q          <= cke_d;
      init_done_q    <= init_done_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd          = cmd_q;
  assign ba           = ba_q;
  assign addr         = addr_q;
  assign cs_n         = cs_n_q;
  assign dram_reset_n = dram_reset_n_q;
  assign cke          = cke_q;
  assign init_state   = state_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_dram_init_sequencer.sv
// Bench for dram_init_sequencer: a single-rank instance (A) and a two-rank
// instance with zero/short timings (B). The expected command list is built
// from the mode-register table, rank count and timing gaps. Each cycle is
// then checked against that list.
module tb_dram_init_sequencer;

  localparam int A_NR = 1, A_NM = 4, A_RST = 3, A_CKE = 5, A_XPR = 2, A_MRD = 4, A_MOD = 12, A_ZQ = 8;
  localparam int B_NR = 2, B_NM = 2, B_RST = 2, B_CKE = 3, B_XPR = 0, B_MRD = 0, B_MOD = 3, B_ZQ = 5;

  typedef struct {
    int nr, nm, t_reset, t_cke, t_xpr, t_mrd, t_mod, t_zq;
  } cfg_t;

  typedef struct {
    int         stall;  // cycles cmd_ready is held low before acceptance
    logic [3:0] cmd;
    logic [2:0] ba;
    logic [13:0] addr;
    logic [1:0] cs_n;
    int         gap;    // idle cycles preceding this command
  } exp_cmd_t;

  logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, cmd_ready = 1'b0, sel = 1'b0;
  logic [67:0] mr_a = '0;
  logic [33:0] mr_b = '0;

  logic a_valid, a_rstn, a_cke, a_done, b_valid, b_rstn, b_cke, b_done;
  logic [3:0] a_cmd, a_state, b_cmd, b_state;
  logic [2:0] a_ba, b_ba;
  logic [13:0] a_addr, b_addr;
  logic [0:0] a_cs;
  logic [1:0] b_cs;

  logic o_valid, o_rstn, o_cke, o_done;
  logic [3:0] o_cmd, o_state;
  logic [2:0] o_ba;
  logic [13:0] o_addr;
  logic [1:0] o_cs;

  int n_tests = 0, n_fail = 0;
  exp_cmd_t exp_q[$];
  exp_cmd_t vec_a[5];

  always #5 clk = ~clk;

  dram_init_sequencer #(.NUM_RANKS(A_NR), .NUM_MRS(A_NM), .CNT_W(20), .T_RESET(A_RST), .T_CKE(A_CKE),
    .T_XPR(A_XPR), .T_MRD(A_MRD), .T_MOD(A_MOD), .T_ZQINIT(A_ZQ)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .init_start(start_a), .mr_table(mr_a), .cmd_ready(cmd_ready),
    .cmd_valid(a_valid), .cmd(a_cmd), .ba(a_ba), .addr(a_addr), .cs_n(a_cs),
    .dram_reset_n(a_rstn), .cke(a_cke), .init_state(a_state), .init_done(a_done));

  dram_init_sequencer #(.NUM_RANKS(B_NR), .NUM_MRS(B_NM), .CNT_W(8), .T_RESET(B_RST), .T_CKE(B_CKE),
    .T_XPR(B_XPR), .T_MRD(B_MRD), .T_MOD(B_MOD), .T_ZQINIT(B_ZQ)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .init_start(start_b), .mr_table(mr_b), .cmd_ready(cmd_ready),
    .cmd_valid(b_valid), .cmd(b_cmd), .ba(b_ba), .addr(b_addr), .cs_n(b_cs),
    .dram_reset_n(b_rstn), .cke(b_cke), .init_state(b_state), .init_done(b_done));

  // Observation mux: the selected instance, cs_n widened to two bits.
  always_comb begin
    if (sel) begin
      {o_valid, o_cmd, o_ba, o_addr, o_cs} = {b_valid, b_cmd, b_ba, b_addr, b_cs};
      {o_rstn, o_cke, o_done, o_state}     = {b_rstn, b_cke, b_done, b_state};
    end else begin
      {o_valid, o_cmd, o_ba, o_addr, o_cs} = {a_valid, a_cmd, a_ba, a_addr, 1'b1, a_cs};
      {o_rstn, o_cke, o_done, o_state}     = {a_rstn, a_cke, a_done, a_state};
    end
  end

  function automatic logic [30:0] pack(input logic [3:0] st, input logic v, input logic [3:0] cm,
      input logic [2:0] b, input logic [13:0] a, input logic [1:0] cs, input logic d, input logic k,
      input logic r);
    return {st, v, cm, b, a, cs, d, k, r};
  endfunction

  function automatic logic [30:0] obs();
    return pack(o_state, o_valid, o_cmd, o_ba, o_addr, o_cs, o_done, o_cke, o_rstn);
  endfunction

  function automatic int eff(input int t);
    return (t < 1) ? 1 : t;
  endfunction

  function automatic cfg_t cfg_of(input logic s);
    cfg_t c;
    if (s) c = '{B_NR, B_NM, B_RST, B_CKE, B_XPR, B_MRD, B_MOD, B_ZQ};
    else   c = '{A_NR, A_NM, A_RST, A_CKE, A_XPR, A_MRD, A_MOD, A_ZQ};
    return c;
  endfunction

  localparam logic [30:0] FULL = '1;
  localparam logic [30:0] GAP_MASK = {4'h0, 1'b1, 4'hF, 3'h0, 14'h0, 2'b11, 1'b1, 1'b1, 1'b1};

  task automatic check_m(input string name, input logic [30:0] act, input logic [30:0] exp,
                         input logic [30:0] mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h (mask %h)", name, $time, act, exp, mask);
    end
  endtask

  // Expected command list derived from the table, rank count and timing gaps.
  task automatic build_list(input logic s, input bit rnd);
    cfg_t c = cfg_of(s);
    logic [67:0] tbl = s ? {34'd0, mr_b} : mr_a;
    exp_cmd_t e;
    exp_q.delete();
    for (int r = 0; r < c.nr; r++) begin
      for (int m = 0; m < c.nm; m++) begin
        e.stall = rnd ? int'($urandom_range(0, 3)) : 0;
        e.cmd = 4'd9;
        {e.ba, e.addr} = tbl[17*m +: 17];
        e.cs_n = ~(2'b01 << r);
        e.gap = (m != 0) ? eff(c.t_mrd) : (r == 0) ? 0 : eff(c.t_zq) + eff(c.t_mrd);
        exp_q.push_back(e);
      end
      e.stall = rnd ? int'($urandom_range(0, 3)) : 0;
      e.cmd = 4'd8; e.ba = 3'd0; e.addr = 14'h0400; e.cs_n = ~(2'b01 << r);
      e.gap = eff(c.t_mod);
      exp_q.push_back(e);
    end
  endtask

  // Plays one init sequence on the selected instance against exp_q.
  task automatic run_seq(input logic s, input int abort_after);
    cfg_t c = cfg_of(s);
    int pre = eff(c.t_reset) + eff(c.t_cke) + eff(c.t_xpr);
    logic [3:0] st;
    sel = s;
    @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    @(negedge clk); if (s) start_b = 1'b1; else start_a = 1'b1;
    for (int t = 0; t < pre; t++) begin
      @(negedge clk);
      st = (t < eff(c.t_reset)) ? 4'd0 : (t < eff(c.t_reset) + eff(c.t_cke)) ? 4'd1 : 4'd2;
      check_m("power_up_phase", obs(), pack(st, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0,
              t >= eff(c.t_reset) + eff(c.t_cke), t >= eff(c.t_reset)), FULL);
      cmd_ready = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      for (int i = 0; i < exp_q[k].gap; i++) begin
        @(negedge clk);
        check_m("wait_gap", obs(), pack(4'd0, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0, 1'b1, 1'b1), GAP_MASK);
        cmd_ready = 1'($urandom_range(0, 1));
        if (k == abort_after + 1 && i == 1) return;
      end
      for (int h = 0; h <= exp_q[k].stall; h++) begin
        @(negedge clk);
        check_m(exp_q[k].cmd == 4'd9 ? "mrs_cmd" : "zqcl_cmd", obs(),
                pack(exp_q[k].cmd == 4'd9 ? 4'd4 : 4'd3, 1'b1, exp_q[k].cmd, exp_q[k].ba,
                     exp_q[k].addr, exp_q[k].cs_n, 1'b0, 1'b1, 1'b1), FULL);
        cmd_ready = (h == exp_q[k].stall);
      end
    end
    for (int i = 0; i < eff(c.t_zq); i++) begin
      @(negedge clk);
      check_m("zq_wait", obs(), pack(4'd0, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0, 1'b1, 1'b1), GAP_MASK);
      cmd_ready = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_m("init_done_hold", obs(), pack(4'd6, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b1, 1'b1, 1'b1), FULL);
    end
  endtask

  initial begin
    vec_a[0] = '{0, 4'd9, 3'd0, 14'h0520, 2'b10, 0};
    vec_a[1] = '{6, 4'd9, 3'd1, 14'h0044, 2'b10, A_MRD};
    vec_a[2] = '{0, 4'd9, 3'd2, 14'h0008, 2'b10, A_MRD};
    vec_a[3] = '{0, 4'd9, 3'd7, 14'h3FFF, 2'b10, A_MRD};
    vec_a[4] = '{0, 4'd8, 3'd0, 14'h0400, 2'b10, A_MOD};
    for (int i = 0; i < 4; i++) mr_a[17*i +: 17] = {vec_a[i].ba, vec_a[i].addr};

    // Reset values on both instances, then idle while init_start is low.
    #12;
    sel = 1'b0; #1;
    check_m("reset_a", obs(), pack(4'd0, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0, 1'b0, 1'b0), FULL);
    sel = 1'b1; #1;
    check_m("reset_b", obs(), pack(4'd0, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0, 1'b0, 1'b0), FULL);
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_m("idle_no_start", obs(), pack(4'd0, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0, 1'b0, 1'b0), FULL);
    end

    // Directed single-rank run from the vector table, 6-cycle stall on MRS #2.
    exp_q.delete();
    foreach (vec_a[i]) exp_q.push_back(vec_a[i]);
    run_seq(1'b0, -1);

    // Re-runs from INIT_DONE with random tables and random stalls.
    for (int n = 0; n < 2; n++) begin
      mr_a = 68'({$urandom(), $urandom(), $urandom()});
      build_list(1'b0, 1'b1);
      run_seq(1'b0, -1);
    end

    // Asynchronous reset while waiting tMOD after the last MRS.
    build_list(1'b0, 1'b0);
    run_seq(1'b0, 3);
    check_m("in_wait_tmod", {27'd0, o_state}, 31'd7, FULL);
    #2 rst_n = 1'b0; start_a = 1'b0;
    @(negedge clk);
    check_m("reset_mid_seq", obs(), pack(4'd0, 1'b0, 4'd0, 3'd0, 14'd0, 2'b11, 1'b0, 1'b0, 1'b0), FULL);
    rst_n = 1'b1;
    run_seq(1'b0, -1);

    // Two ranks, T_MRD = 0 and T_XPR = 0, random tables and stalls.
    for (int n = 0; n < 3; n++) begin
      mr_b = 34'({$urandom(), $urandom()});
      build_list(1'b1, n != 0);
      run_seq(1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
